// File: rtl/fib_pkg.sv
// Purpose : shared types and constants for the Fibonacci sequencer slice.
// Latency : n/a (package only).
// Backpressure: n/a.
package fib_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_RESP = 2'b10
    } fib_state_t;

    localparam int WIDTH_DEF = 16;
    localparam int IDX_W_DEF = 5;

    // Largest index whose Fibonacci value fits in 16 bits without a carry-out.
    localparam int FIB_MAX_NO_OVF_16 = 24;

endpackage

// File: rtl/fib_step_dp.sv
// Purpose : prev/cur register pair with one adder; load seeds (0,1), step advances one term.
// Latency : one clock per load/step; o_carry is combinational from the current registers.
// Backpressure: none; the controller decides when to load or step.
// Ports   : clk, rst_n, i_load, i_step -> o_cur (current term), o_carry (carry of cur+prev).
module fib_step_dp #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_step,
    output logic [WIDTH-1:0] o_cur,
    output logic             o_carry
);

    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_cur;
    logic [WIDTH:0]   w_sum;

    assign w_sum   = {1'b0, r_cur} + {1'b0, r_prev};
    assign o_cur   = r_cur;
    assign o_carry = w_sum[WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= '0;
            r_cur  <= '0;
        end else if (i_load) begin
            r_prev <= '0;
            r_cur  <= {{(WIDTH-1){1'b0}}, 1'b1};
        end else if (i_step) begin
            r_prev <= r_cur;
            r_cur  <= w_sum[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/fib_seq_ctrl.sv
// Purpose : accepts index n, sequences the add datapath, returns fib(n) mod 2^WIDTH with sticky overflow.
// Latency : rsp_valid rises max(n,1) edges after the accept edge.
// Backpressure: one request at a time; req_ready only in IDLE, result held in RESP until rsp_ready.
// Ports   : req_valid/req_ready/req_n in, rsp_valid/rsp_ready/rsp_value/rsp_ovf out, busy = not IDLE.
module fib_seq_ctrl
    import fib_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [IDX_W-1:0] req_n,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_value,
    output logic             rsp_ovf,
    output logic             busy
);

    fib_state_t       r_state;
    fib_state_t       w_state_nxt;
    logic [IDX_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_n;
    logic             r_ovf;
    logic [WIDTH-1:0] r_result;

    logic             w_load;
    logic             w_step;
    logic             w_done;
    logic [WIDTH-1:0] w_cur;
    logic             w_carry;

    fib_step_dp #(.WIDTH(WIDTH)) u_dp (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_step  (w_step),
        .o_cur   (w_cur),
        .o_carry (w_carry)
    );

    // n==0 makes one pass through RUN like n==1, so every request costs
    // max(n,1) edges and the result mux below supplies the zero.
    assign w_done = (r_n == '0) || (r_cnt == r_n);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_done) begin
                    w_state_nxt = ST_RESP;
                end else begin
                    w_step = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_n      <= '0;
            r_ovf    <= 1'b0;
            r_result <= '0;
        end else begin
            if (r_state == ST_IDLE && req_valid) begin
                r_n   <= req_n;
                r_ovf <= 1'b0;
                r_cnt <= {{(IDX_W-1){1'b0}}, 1'b1};
            end else if (r_state == ST_RUN) begin
                if (w_done) begin
                    r_result <= (r_n == '0) ? '0 : w_cur;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                    r_ovf <= r_ovf | w_carry;
                end
            end
        end
    end

    assign req_ready = (r_state == ST_IDLE);
    assign rsp_valid = (r_state == ST_RESP);
    assign busy      = (r_state != ST_IDLE);
    assign rsp_value = r_result;
    assign rsp_ovf   = r_ovf;

endmodule

// File: tb/tb_fib_seq_ctrl.sv
module tb_fib_seq_ctrl;
    import fib_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_n;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_value;
    logic        rsp_ovf;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fib_seq_ctrl #(.WIDTH(16), .IDX_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_n     (req_n),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_value (rsp_value),
        .rsp_ovf   (rsp_ovf),
        .busy      (busy)
    );

    typedef struct {
        logic [4:0]  n;
        logic [15:0] v;
        logic        o;
        int          lat;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain iteration on wide integers, then wrap; overflow happens
    // exactly when the true value no longer fits in 16 bits.
    task automatic model(input int n, output logic [15:0] v, output logic o, output int lat);
        longint a, b, t;
        a = 0;
        b = 1;
        for (int k = 0; k < n; k++) begin
            t = a + b;
            a = b;
            b = t;
        end
        v   = a[15:0];
        o   = (a > 65535);
        lat = (n == 0) ? 1 : n;
    endtask

    // One full transaction with `stall` cycles of rsp_ready=0 after rsp_valid.
    task automatic do_req(input string name, input logic [4:0] n, input int stall,
                          input logic [15:0] ev, input logic eo, input int elat);
        int lat;
        bit tmo;
        @(negedge clk);
        req_valid = 1'b1;
        req_n     = n;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_n     = 5'($urandom);
        lat = 0;
        tmo = 0;
        while (!rsp_valid) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat > 100) begin
                tmo = 1;
                break;
            end
        end
        chk({name, " timeout"}, tmo, 0);
        chk({name, " latency"}, lat, elat);
        chk({name, " value"}, rsp_value, ev);
        chk({name, " ovf"}, rsp_ovf, eo);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk({name, " stall valid"}, rsp_valid, 1);
            chk({name, " stall value"}, rsp_value, ev);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk({name, " busy after hs"}, busy, 0);
        chk({name, " valid after hs"}, rsp_valid, 0);
    endtask

    initial begin
        logic [15:0] mv;
        logic        mo;
        int          ml;
        int          lat;
        int          seen;

        tbl[0] = '{5'd10, 16'd55,    1'b0, 10};
        tbl[1] = '{5'd0,  16'd0,     1'b0, 1};
        tbl[2] = '{5'd1,  16'd1,     1'b0, 1};
        tbl[3] = '{5'd2,  16'd1,     1'b0, 2};
        tbl[4] = '{5'(FIB_MAX_NO_OVF_16), 16'd46368, 1'b0, 24};
        tbl[5] = '{5'd25, 16'd9489,  1'b1, 25};
        tbl[6] = '{5'd31, 16'd35549, 1'b1, 31};
        tbl[7] = '{5'd20, 16'd6765,  1'b0, 20};

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_n     = '0;
        rsp_ready = 1'b0;
        #12;
        chk("rst rsp_valid", rsp_valid, 0);
        chk("rst rsp_value", rsp_value, 0);
        chk("rst rsp_ovf", rsp_ovf, 0);
        chk("rst busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst req_ready", req_ready, 1);

        for (int i = 0; i < 8; i++) begin
            do_req($sformatf("tbl%0d", i), tbl[i].n, 0, tbl[i].v, tbl[i].o, tbl[i].lat);
        end

        // Backpressure with a competing request held on the request port.
        @(negedge clk);
        req_valid = 1'b1;
        req_n     = 5'd7;
        @(posedge clk);
        #1;
        req_n = 5'd3;
        lat = 0;
        while (!rsp_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("bp latency", lat, 7);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp valid", rsp_valid, 1);
            chk("bp value", rsp_value, 13);
            chk("bp req_ready", req_ready, 0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk("bp idle after hs", busy, 0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("bp next latency", lat, 3);
        chk("bp next value", rsp_value, 2);
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;

        // Reset asserted in the middle of a run.
        @(negedge clk);
        req_valid = 1'b1;
        req_n     = 5'd20;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst rsp_valid", rsp_valid, 0);
        chk("midrst busy", busy, 0);
        chk("midrst rsp_value", rsp_value, 0);
        chk("midrst rsp_ovf", rsp_ovf, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk("midrst no rsp", seen, 0);
        do_req("midrst retry", 5'd20, 0, 16'd6765, 1'b0, 20);

        // Random indices with random response stalls against the model.
        for (int i = 0; i < 8; i++) begin
            int n;
            n = $urandom_range(0, 31);
            model(n, mv, mo, ml);
            do_req($sformatf("rnd%0d_n%0d", i, n), 5'(n), $urandom_range(0, 3), mv, mo, ml);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
